bcd_seq_calc: RTL

- Sequential controller for the BCD add/subtract datapath.
- Collects two multi-digit BCD operands from digit-key pulses, one digit at a time, plus an add/subtract operator.
- On "equals", runs a single shared one-digit BCD adder serially, least-significant digit (LSD) first, and presents the result with overflow/underflow and invalid-input flags for the 7-segment display logic.
- Sits between the debounced key/switch front end and the HEX/LEDG decoders.

---
 rtl/bcd_seq_calc_pkg.sv | 18 +
 rtl/bcd_digit_adder.sv | 29 ++
 rtl/bcd_seq_calc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_calc_pkg.sv
// Shared definitions for the sequential BCD calculator.
//   state_t  : controller states
//   BCD_MAX  : largest legal BCD digit
//   DISP_ERR : per-digit display code shown for blank/error
package bcd_seq_calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    EXEC,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] DISP_ERR = 4'hF;

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal correction.
//   a, b : BCD digits (0..9)
//   cin  : carry in
//   s    : BCD sum digit
//   cout : decimal carry out (raw sum 10..19)
module bcd_digit_adder
  import bcd_seq_calc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > {1'b0, BCD_MAX}) begin
      s    = 4'(raw + 5'd6);
      cout = 1'b1;
    end else begin
      s    = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_calc.sv
// Sequential BCD add/subtract controller.
// Collects two DIGITS-digit BCD operands from key strobes, then runs one
// shared digit adder serially (LSD first) for DIGITS cycles.
//   CLOCK_50    : clock            rst      : async active-high reset
//   clr         : sync clear       digit_valid/digit : digit key strobe
//   op_valid/op_sub : operator key (1 = subtract)
//   eq_valid    : execute strobe
//   disp        : operand under entry or result (all-ones on error/ovf)
//   busy        : executing        done     : one-cycle result pulse
//   ovf         : carry-out / borrow       err : non-BCD digit entered
module bcd_seq_calc
  import bcd_seq_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  op_valid,
  input  logic                  op_sub,
  input  logic                  eq_valid,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);

  state_t        state, nxt_state;
  logic [W-1:0]  a_reg, nxt_a;
  logic [W-1:0]  b_reg, nxt_b;
  logic [W-1:0]  res_reg, nxt_res;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [IW-1:0] idx, nxt_idx;
  logic          carry, nxt_carry;
  logic          sub, nxt_sub;
  logic          ovf_reg, nxt_ovf;
  logic          done_reg, nxt_done;

  logic [3:0]    a_dig, b_dig, b_op, sum_dig;
  logic          sum_cout;
  logic [W-1:0]  shift_a, shift_b;

  always_comb begin
    a_dig   = a_reg[4*int'(idx) +: 4];
    b_dig   = b_reg[4*int'(idx) +: 4];
    b_op    = sub ? (BCD_MAX - b_dig) : b_dig;
    shift_a = a_reg << 4;
    shift_a[3:0] = digit;
    shift_b = b_reg << 4;
    shift_b[3:0] = digit;
  end

  bcd_digit_adder u_add (
    .a    (a_dig),
    .b    (b_op),
    .cin  (carry),
    .s    (sum_dig),
    .cout (sum_cout)
  );

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state    <= ENTER_A;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      cnt      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sub      <= 1'b0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= nxt_state;
      a_reg    <= nxt_a;
      b_reg    <= nxt_b;
      res_reg  <= nxt_res;
      cnt      <= nxt_cnt;
      idx      <= nxt_idx;
      carry    <= nxt_carry;
      sub      <= nxt_sub;
      ovf_reg  <= nxt_ovf;
      done_reg <= nxt_done;
    end
  end

  // Strobe priority clr > eq > op > digit: each branch consumes the
  // highest-priority strobe and drops the rest, even when it is a no-op.
  always_comb begin
    nxt_state = state;
    nxt_a     = a_reg;
    nxt_b     = b_reg;
    nxt_res   = res_reg;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_carry = carry;
    nxt_sub   = sub;
    nxt_ovf   = ovf_reg;
    nxt_done  = 1'b0;
    if (clr) begin
      nxt_state = ENTER_A;
      nxt_a     = '0;
      nxt_b     = '0;
      nxt_res   = '0;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_carry = 1'b0;
      nxt_sub   = 1'b0;
      nxt_ovf   = 1'b0;
    end else begin
      unique case (state)
        ENTER_A: begin
          if (eq_valid) begin
          end else if (op_valid) begin
            nxt_sub   = op_sub;
            nxt_b     = '0;
            nxt_cnt   = '0;
            nxt_state = ENTER_B;
          end else if (digit_valid) begin
            if (digit > BCD_MAX) begin
              nxt_state = ERR;
            end else if (cnt != CNT_MAX) begin
              nxt_a   = shift_a;
              nxt_cnt = cnt + 1'b1;
            end
          end
        end
        ENTER_B: begin
          if (eq_valid) begin
            nxt_res   = '0;
            nxt_idx   = '0;
            nxt_carry = sub;
            nxt_state = EXEC;
          end else if (op_valid) begin
            nxt_sub = op_sub;
          end else if (digit_valid) begin
            if (digit > BCD_MAX) begin
              nxt_state = ERR;
            end else if (cnt != CNT_MAX) begin
              nxt_b   = shift_b;
              nxt_cnt = cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          nxt_res[4*int'(idx) +: 4] = sum_dig;
          nxt_carry = sum_cout;
          if (idx == IDX_LAST) begin
            nxt_ovf   = sub ? ~sum_cout : sum_cout;
            nxt_done  = 1'b1;
            nxt_state = DONE;
          end else begin
            nxt_idx = idx + 1'b1;
          end
        end
        DONE: begin
          if (eq_valid) begin
          end else if (op_valid) begin
            nxt_a     = ovf_reg ? '0 : res_reg;
            nxt_sub   = op_sub;
            nxt_b     = '0;
            nxt_cnt   = '0;
            nxt_ovf   = 1'b0;
            nxt_state = ENTER_B;
          end else if (digit_valid) begin
            nxt_a      = '0;
            nxt_a[3:0] = digit;
            nxt_cnt    = CW'(1);
            nxt_ovf    = 1'b0;
            nxt_state  = ENTER_A;
          end
        end
        ERR: begin
        end
        default: nxt_state = ENTER_A;
      endcase
    end
  end

  always_comb begin
    disp = '0;
    unique case (state)
      ENTER_A:       disp = a_reg;
      ENTER_B, EXEC: disp = b_reg;
      DONE:          disp = ovf_reg ? {DIGITS{DISP_ERR}} : res_reg;
      ERR:           disp = {DIGITS{DISP_ERR}};
      default:       disp = '0;
    endcase
  end

  assign busy = (state == EXEC);
  assign done = done_reg;
  assign ovf  = ovf_reg;
  assign err  = (state == ERR);

endmodule
